// File: rtl/simple_tpu_dot_seq.sv
// ============================================================================
// simple_tpu_dot_seq
//
// Dot-product sequencer placed directly in front of simple_tpu_mac. It takes
// a stream of (a, b) element pairs, issues them to the MAC one at a time and
// feeds every MAC result back as the next addend. The last MAC result is
// therefore bias + sum(a[i] * b[i]). All arithmetic happens inside the MAC;
// this block only sequences operands and tracks progress.
//
// Parameters:
//   LEN_WIDTH     width of the vector-length field
//   TIMEOUT       cycles the block will wait for a MAC result before aborting
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start                   one-cycle request, honoured only when idle
//   length, data_type, bias run parameters, captured on an accepted start
//   elem_valid/elem_ready   element-pair handshake from upstream
//   a_elem, b_elem          element operands
//   mac_enable              MAC enable (high whenever a run is active)
//   mac_data_type           data type of the current run
//   mac_a, mac_b, mac_c     MAC operands, forced to zero when not issuing
//   mac_valid_in            MAC issue strobe
//   mac_ready               MAC can accept an operation
//   mac_result              MAC result, valid with mac_valid_out
//   mac_valid_out           MAC result strobe
//   busy                    high in any state other than idle
//   done                    one-cycle completion pulse
//   error                   one-cycle watchdog timeout pulse
//   dot_result              final result, held until a later run completes
// ============================================================================
module simple_tpu_dot_seq #(
    parameter int LEN_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [2:0]           data_type,
    input  logic [31:0]          bias,
    input  logic                 elem_valid,
    output logic                 elem_ready,
    input  logic [15:0]          a_elem,
    input  logic [15:0]          b_elem,
    output logic                 mac_enable,
    output logic [2:0]           mac_data_type,
    output logic [15:0]          mac_a,
    output logic [15:0]          mac_b,
    output logic [31:0]          mac_c,
    output logic                 mac_valid_in,
    input  logic                 mac_ready,
    input  logic [31:0]          mac_result,
    input  logic                 mac_valid_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          dot_result
);

    // The watchdog only ever needs to count up to TIMEOUT-1.
    localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [31:0]          acc;
    logic [LEN_WIDTH-1:0] remaining;
    logic [2:0]           dt_q;
    logic [WD_WIDTH-1:0]  wd;
    logic                 in_issue;
    logic                 handshake;

    // Issue path is combinational so an element can be handed to the MAC in
    // the same cycle the upstream presents it. Operands are zeroed whenever
    // no issue happens so the MAC never sees stale data.
    assign in_issue      = (state == S_ISSUE);
    assign handshake     = in_issue && elem_valid && mac_ready;
    assign elem_ready    = in_issue && mac_ready;
    assign mac_valid_in  = handshake;
    assign mac_a         = handshake ? a_elem : 16'd0;
    assign mac_b         = handshake ? b_elem : 16'd0;
    assign mac_c         = handshake ? acc : 32'd0;

    assign busy          = (state != S_IDLE);
    assign mac_enable    = busy;
    assign mac_data_type = dt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            remaining  <= '0;
            dt_q       <= '0;
            wd         <= '0;
            dot_result <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= length;
                        dt_q      <= data_type;
                        acc       <= bias;
                        state     <= (length == '0) ? S_DONE : S_ISSUE;
                    end
                end
                // Upstream stalls are legal here, so the watchdog is idle.
                S_ISSUE: begin
                    if (handshake) begin
                        wd    <= '0;
                        state <= S_WAIT;
                    end
                end
                // A result always wins over a timeout landing in the same cycle.
                S_WAIT: begin
                    if (mac_valid_out) begin
                        acc       <= mac_result;
                        remaining <= remaining - LEN_ONE;
                        state     <= (remaining == LEN_ONE) ? S_DONE : S_ISSUE;
                    end else if (wd == WD_LAST) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + WD_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    dot_result <= acc;
                    done       <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_tpu_dot_seq.sv
// ============================================================================
// tb_simple_tpu_dot_seq
//
// Self-checking bench for simple_tpu_dot_seq. A small behavioural MAC answers
// every issue one cycle later with a*b + c. Expected results come from a
// reference model that sums the element products directly.
// ============================================================================
module tb_simple_tpu_dot_seq;

    localparam int LEN_WIDTH = 8;
    localparam int TIMEOUT   = 16;
    localparam int BUDGET    = 2000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LEN_WIDTH-1:0] length = '0;
    logic [2:0]           data_type = '0;
    logic [31:0]          bias = '0;
    logic                 elem_valid = 1'b0;
    logic                 elem_ready;
    logic [15:0]          a_elem = '0;
    logic [15:0]          b_elem = '0;
    logic                 mac_enable;
    logic [2:0]           mac_data_type;
    logic [15:0]          mac_a;
    logic [15:0]          mac_b;
    logic [31:0]          mac_c;
    logic                 mac_valid_in;
    logic                 mac_ready = 1'b1;
    logic [31:0]          mac_result = '0;
    logic                 mac_valid_out = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [31:0]          dot_result;

    always #5 clk = ~clk;

    simple_tpu_dot_seq #(
        .LEN_WIDTH(LEN_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length       (length),
        .data_type    (data_type),
        .bias         (bias),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .a_elem       (a_elem),
        .b_elem       (b_elem),
        .mac_enable   (mac_enable),
        .mac_data_type(mac_data_type),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_c        (mac_c),
        .mac_valid_in (mac_valid_in),
        .mac_ready    (mac_ready),
        .mac_result   (mac_result),
        .mac_valid_out(mac_valid_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .dot_result   (dot_result)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] a_vec [256];
    logic [15:0] b_vec [256];
    logic [31:0] last_dot = '0;

    // Observations collected by run_dot
    int obs_done_cyc, obs_err_cyc, obs_first_xfer, obs_busy, obs_viol;
    int obs_done_pulses, obs_err_pulses;

    // Operations the MAC actually received
    logic [15:0] seen_a [$];
    logic [15:0] seen_b [$];
    logic [31:0] seen_c [$];

    // MAC semantics: INT8 uses only the low byte, other types full 16 bits,
    // unsigned and modulo 2^32.
    function automatic logic [31:0] mac_product(input logic [2:0] dt, input logic [15:0] a,
                                                input logic [15:0] b);
        if (dt == 3'b000) return 32'(a[7:0]) * 32'(b[7:0]);
        return 32'(a) * 32'(b);
    endfunction

    // Reference: bias plus the sum of the first len products.
    function automatic logic [31:0] ref_dot(input int len, input logic [2:0] dt,
                                            input logic [31:0] bias_v);
        logic [31:0] s;
        s = bias_v;
        for (int i = 0; i < len; i++) s = s + mac_product(dt, a_vec[i], b_vec[i]);
        return s;
    endfunction

    // Behavioural MAC: answers one cycle after each issue unless hung.
    logic        mac_hang = 1'b0;
    logic        em_fire;
    logic [31:0] em_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_valid_out = 1'b0;
            mac_result    = '0;
        end else begin
            em_fire = mac_valid_in && !mac_hang;
            em_res  = '0;
            if (mac_valid_in) begin
                seen_a.push_back(mac_a);
                seen_b.push_back(mac_b);
                seen_c.push_back(mac_c);
                em_res = mac_product(mac_data_type, mac_a, mac_b) + mac_c;
            end
            #1;
            mac_valid_out = em_fire;
            mac_result    = em_fire ? em_res : $urandom;
        end
    end

    // Drives one run. mode 0: no stalls; 1: random elem_valid/mac_ready;
    // 2: five idle cycles before each element plus a start pulse mid-run.
    task automatic run_dot(input int len, input logic [2:0] dt, input logic [31:0] bias_v,
                           input int mode);
        int idx, stall, cyc, tail;
        bit xfer;
        seen_a.delete(); seen_b.delete(); seen_c.delete();
        obs_done_cyc = -1; obs_err_cyc = -1; obs_first_xfer = -1;
        obs_busy = 0; obs_viol = 0; obs_done_pulses = 0; obs_err_pulses = 0;
        @(negedge clk);
        start = 1'b1; length = LEN_WIDTH'(len); data_type = dt; bias = bias_v;
        elem_valid = 1'b0; mac_ready = 1'b1;
        @(posedge clk);
        cyc = 0; idx = 0; tail = -1;
        stall = (mode == 2) ? 5 : 0;
        while (cyc < BUDGET && tail != 0) begin
            @(negedge clk);
            start = (mode == 2 && cyc == 4);
            length = LEN_WIDTH'($urandom); data_type = 3'($urandom); bias = $urandom;
            if (busy) obs_busy++;
            if (done) begin obs_done_pulses++; if (obs_done_cyc < 0) obs_done_cyc = cyc; end
            if (error) begin obs_err_pulses++; if (obs_err_cyc < 0) obs_err_cyc = cyc; end
            if (done && error) obs_viol++;
            if (tail > 0) tail--;
            else if (tail < 0 && (done || error)) tail = 1;
            if (idx < len && tail < 0) begin
                if (stall > 0) begin elem_valid = 1'b0; stall--; end
                else if (mode == 1) elem_valid = 1'($urandom_range(0, 1));
                else elem_valid = 1'b1;
            end else begin
                elem_valid = 1'b0;
            end
            a_elem = elem_valid ? a_vec[idx] : 16'($urandom);
            b_elem = elem_valid ? b_vec[idx] : 16'($urandom);
            mac_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (mac_enable !== busy) obs_viol++;
            if (elem_ready === 1'b1 && mac_ready !== 1'b1) obs_viol++;
            if (mac_valid_in !== (elem_valid && elem_ready)) obs_viol++;
            if (mac_valid_in === 1'b1) begin
                if (mac_a !== a_elem || mac_b !== b_elem) obs_viol++;
            end else if (mac_a !== 16'd0 || mac_b !== 16'd0 || mac_c !== 32'd0) begin
                obs_viol++;
            end
            if (busy === 1'b1 && mac_data_type !== dt) obs_viol++;
            xfer = elem_valid && elem_ready;
            @(posedge clk);
            cyc++;
            if (xfer) begin
                idx++;
                stall = (mode == 2) ? 5 : 0;
                if (obs_first_xfer < 0) obs_first_xfer = cyc;
            end
        end
        @(negedge clk);
        elem_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; elem_valid = 1'b1; mac_ready = 1'b1; length = 8'd3;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, elem_ready, mac_valid_in, mac_enable} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {busy, done, error, elem_ready, mac_valid_in, mac_enable});
        end
        checks++;
        if ({mac_data_type, mac_a, mac_b, mac_c, dot_result} !== 99'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got dt=%0d a=%h b=%h c=%h dot=%h expected all zero",
                     mac_data_type, mac_a, mac_b, mac_c, dot_result);
        end
        start = 1'b0; elem_valid = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic_dot;
        logic [31:0] exp_c [3];
        exp_c = '{32'd10, 32'd20, 32'd38};
        a_vec[0] = 16'd2; a_vec[1] = 16'd3; a_vec[2] = 16'd4;
        b_vec[0] = 16'd5; b_vec[1] = 16'd6; b_vec[2] = 16'd7;
        run_dot(3, 3'b001, 32'd10, 0);
        checks++;
        if (obs_done_cyc !== 7) begin
            failures++; $display("[TB] FAIL basic_latency: got %0d expected 7", obs_done_cyc);
        end
        checks++;
        if (dot_result !== 32'd66) begin
            failures++; $display("[TB] FAIL basic_result: got %0d expected 66", dot_result);
        end
        checks++;
        if (seen_c.size() !== 3) begin
            failures++; $display("[TB] FAIL basic_issue_count: got %0d expected 3", seen_c.size());
        end
        for (int i = 0; i < 3 && i < seen_c.size(); i++) begin
            checks++;
            if (seen_c[i] !== exp_c[i]) begin
                failures++;
                $display("[TB] FAIL basic_mac_c[%0d]: got %0d expected %0d", i, seen_c[i], exp_c[i]);
            end
        end
        checks++;
        if (obs_busy !== 7 || obs_done_pulses !== 1 || obs_err_pulses !== 0 || obs_viol !== 0) begin
            failures++;
            $display("[TB] FAIL basic_protocol: got busy=%0d done=%0d err=%0d viol=%0d expected 7 1 0 0",
                     obs_busy, obs_done_pulses, obs_err_pulses, obs_viol);
        end
        last_dot = 32'd66;
    endtask

    task automatic test_zero_length;
        run_dot(0, 3'b001, 32'd7, 0);
        checks++;
        if (obs_done_cyc !== 1) begin
            failures++; $display("[TB] FAIL zero_latency: got %0d expected 1", obs_done_cyc);
        end
        checks++;
        if (dot_result !== 32'd7) begin
            failures++; $display("[TB] FAIL zero_result: got %0d expected 7", dot_result);
        end
        checks++;
        if (seen_c.size() !== 0 || obs_busy !== 1 || obs_viol !== 0) begin
            failures++;
            $display("[TB] FAIL zero_protocol: got issues=%0d busy=%0d viol=%0d expected 0 1 0",
                     seen_c.size(), obs_busy, obs_viol);
        end
        last_dot = 32'd7;
    endtask

    task automatic test_int8;
        a_vec[0] = 16'h0103; b_vec[0] = 16'h0002;
        run_dot(1, 3'b000, 32'd0, 0);
        checks++;
        if (seen_a.size() !== 1 || seen_a[0] !== 16'h0103) begin
            failures++;
            $display("[TB] FAIL int8_passthrough: got n=%0d a=%h expected 1 0103", seen_a.size(), seen_a[0]);
        end
        checks++;
        if (dot_result !== 32'd6) begin
            failures++; $display("[TB] FAIL int8_result: got %0d expected 6", dot_result);
        end
        last_dot = 32'd6;
    endtask

    task automatic test_back_to_back;
        int lens [2];
        logic [31:0] exp;
        lens = '{1, 5};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < lens[r]; i++) begin
                a_vec[i] = 16'($urandom); b_vec[i] = 16'($urandom);
            end
            exp = ref_dot(lens[r], 3'b010, 32'(r * 100));
            run_dot(lens[r], 3'b010, 32'(r * 100), 0);
            checks++;
            if (obs_done_cyc !== 2 * lens[r] + 1) begin
                failures++;
                $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", r, obs_done_cyc, 2 * lens[r] + 1);
            end
            checks++;
            if (dot_result !== exp) begin
                failures++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", r, dot_result, exp);
            end
            last_dot = exp;
        end
    endtask

    task automatic test_stalls_restart;
        logic [31:0] bias_v, exp;
        bias_v = $urandom;
        for (int i = 0; i < 2; i++) begin a_vec[i] = 16'($urandom); b_vec[i] = 16'($urandom); end
        exp = ref_dot(2, 3'b011, bias_v);
        run_dot(2, 3'b011, bias_v, 2);
        checks++;
        if (dot_result !== exp) begin
            failures++; $display("[TB] FAIL stall_result: got %h expected %h", dot_result, exp);
        end
        checks++;
        if (seen_a.size() !== 2 || obs_done_pulses !== 1 || obs_viol !== 0) begin
            failures++;
            $display("[TB] FAIL stall_protocol: got issues=%0d done=%0d viol=%0d expected 2 1 0",
                     seen_a.size(), obs_done_pulses, obs_viol);
        end
        for (int i = 0; i < 2 && i < seen_a.size(); i++) begin
            checks++;
            if (seen_a[i] !== a_vec[i] || seen_b[i] !== b_vec[i]) begin
                failures++;
                $display("[TB] FAIL stall_elem[%0d]: got %h,%h expected %h,%h",
                         i, seen_a[i], seen_b[i], a_vec[i], b_vec[i]);
            end
        end
        last_dot = exp;
    endtask

    task automatic test_random;
        int len;
        logic [2:0] dt;
        logic [31:0] bias_v, exp;
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 12);
            dt = 3'($urandom);
            bias_v = $urandom;
            for (int i = 0; i < len; i++) begin a_vec[i] = 16'($urandom); b_vec[i] = 16'($urandom); end
            exp = ref_dot(len, dt, bias_v);
            run_dot(len, dt, bias_v, 1);
            checks++;
            if (dot_result !== exp || obs_done_pulses !== 1) begin
                failures++;
                $display("[TB] FAIL rand_result[%0d]: got %h done=%0d expected %h done=1",
                         r, dot_result, obs_done_pulses, exp);
            end
            checks++;
            if (seen_c.size() !== len || obs_viol !== 0 || obs_busy !== obs_done_cyc
                || obs_done_cyc < 2 * len + 1) begin
                failures++;
                $display("[TB] FAIL rand_protocol[%0d]: got issues=%0d viol=%0d busy=%0d done_cyc=%0d expected %0d 0 done_cyc>=%0d",
                         r, seen_c.size(), obs_viol, obs_busy, obs_done_cyc, len, 2 * len + 1);
            end
            for (int i = 0; i < len && i < seen_c.size(); i++) begin
                checks++;
                if (seen_a[i] !== a_vec[i] || seen_b[i] !== b_vec[i] || seen_c[i] !== ref_dot(i, dt, bias_v)) begin
                    failures++;
                    $display("[TB] FAIL rand_issue[%0d][%0d]: got %h,%h,%h expected %h,%h,%h", r, i,
                             seen_a[i], seen_b[i], seen_c[i], a_vec[i], b_vec[i], ref_dot(i, dt, bias_v));
                end
            end
            last_dot = exp;
        end
    endtask

    task automatic test_watchdog;
        a_vec[0] = 16'd9; b_vec[0] = 16'd9; a_vec[1] = 16'd1; b_vec[1] = 16'd1;
        mac_hang = 1'b1;
        run_dot(2, 3'b001, 32'd5, 0);
        mac_hang = 1'b0;
        checks++;
        if (obs_first_xfer < 0 || obs_err_cyc !== obs_first_xfer + TIMEOUT) begin
            failures++;
            $display("[TB] FAIL wd_latency: got error at %0d expected %0d", obs_err_cyc, obs_first_xfer + TIMEOUT);
        end
        checks++;
        if (obs_err_pulses !== 1 || obs_done_pulses !== 0 || obs_viol !== 0 || seen_a.size() !== 1) begin
            failures++;
            $display("[TB] FAIL wd_pulses: got err=%0d done=%0d viol=%0d issues=%0d expected 1 0 0 1",
                     obs_err_pulses, obs_done_pulses, obs_viol, seen_a.size());
        end
        checks++;
        if (dot_result !== last_dot) begin
            failures++; $display("[TB] FAIL wd_hold_result: got %h expected %h", dot_result, last_dot);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("[TB] FAIL wd_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run;
        for (int i = 0; i < 4; i++) begin a_vec[i] = 16'($urandom); b_vec[i] = 16'($urandom); end
        @(negedge clk);
        start = 1'b1; length = 8'd4; data_type = 3'b101; bias = 32'd77;
        mac_ready = 1'b1; elem_valid = 1'b1; a_elem = a_vec[0]; b_elem = b_vec[0];
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || elem_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_mid_in_wait: got busy=%b ready=%b expected 1 0", busy, elem_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, elem_ready, mac_valid_in, mac_enable} !== 6'b0
            || {mac_data_type, mac_c, dot_result} !== 67'd0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs: got flags=%b dt=%0d c=%h dot=%h expected all zero",
                     {busy, done, error, elem_ready, mac_valid_in, mac_enable}, mac_data_type, mac_c, dot_result);
        end
        elem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_vec[0] = 16'd3; b_vec[0] = 16'd3;
        run_dot(1, 3'b001, 32'd1, 0);
        checks++;
        if (dot_result !== 32'd10 || obs_done_cyc !== 3) begin
            failures++;
            $display("[TB] FAIL rst_mid_rerun: got %0d at cycle %0d expected 10 at cycle 3", dot_result, obs_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_dot();
        test_zero_length();
        test_int8();
        test_back_to_back();
        test_stalls_restart();
        test_random();
        test_watchdog();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no completion expected finish within 50000 cycles");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
